// File: rtl/sqm_pkg.sv
// Shared types and constants for the square-and-multiply sequencer.
package sqm_pkg;

  localparam int SQM_W_A = 8;
  localparam int SQM_W_B = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    MULT   = 2'd2,
    DONE   = 2'd3
  } sqm_state_t;

  // Leading-one position; an all-zero input reports position 0.
  function automatic int unsigned msb_index(input logic [31:0] b);
    msb_index = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) msb_index = i;
    end
  endfunction

endpackage

// File: rtl/sqm_sequencer_if.sv
// Request/result handshake bundle between a requester and sqm_sequencer.
interface sqm_sequencer_if
  import sqm_pkg::*;
#(
  parameter int W_A = SQM_W_A,
  parameter int W_B = SQM_W_B
);

  logic           in_valid;
  logic           in_ready;
  logic [W_A-1:0] A;
  logic [W_B-1:0] B;
  logic           out_valid;
  logic           out_ready;
  logic [W_A-1:0] Y;

  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Y);
  modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, Y);

endinterface

// File: rtl/sqm_mul.sv
// Shared combinational W x W multiplier keeping only the low W product bits.
module sqm_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic [W-1:0] prod
);

  // Context width W truncates the 2W-bit product to its low half.
  assign prod = op_a * op_b;

endmodule

// File: rtl/sqm_sequencer.sv
// Sequential Y = A^B mod 2^W_A via square-and-multiply on one shared multiplier.
// Optional build macro SQM_EARLY_EXIT_EN starts at the exponent's leading one.
module sqm_sequencer
  import sqm_pkg::*;
#(
  parameter int W_A = SQM_W_A,
  parameter int W_B = SQM_W_B
) (
  input  logic              clk,
  input  logic              reset,
  sqm_sequencer_if.slave    bus,
  output logic              busy
);

  localparam int IDX_W = (W_B > 1) ? $clog2(W_B) : 1;

  sqm_state_t       state_q, state_d;
  logic [W_A-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W_A-1:0]   a_q, a_d;
  logic [W_B-1:0]   b_q, b_d;
  logic [W_A-1:0]   y_q, y_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [W_A-1:0]   mul_b;
  logic [W_A-1:0]   prod;

  assign mul_b = (state_q == MULT) ? a_q : acc_q;

  sqm_mul #(.W(W_A)) u_mul (
    .op_a (acc_q),
    .op_b (mul_b),
    .prod (prod)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          acc_d   = W_A'(1);
`ifdef SQM_EARLY_EXIT_EN
          // B==0 lands on idx 0: a single squaring of 1 then DONE.
          idx_d   = IDX_W'(msb_index(32'(bus.B)));
`else
          idx_d   = IDX_W'(W_B - 1);
`endif
          state_d = SQUARE;
        end else begin
          state_d = IDLE;
        end
      end
      SQUARE: begin
        acc_d = prod;
        if (b_q[idx_q]) begin
          state_d = MULT;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      MULT: begin
        acc_d = prod;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQUARE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    if (state_d == DONE) begin
      y_d = acc_d;
    end else begin
      y_d = y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= W_A'(1);
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      y_q         <= y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Y         = y_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sqm_sequencer.sv
// Directed and exhaustive checks of sqm_sequencer results, latency and handshakes.
module tb_sqm_sequencer;

  logic clk;
  logic reset;
  logic busy;
  int   errors;
  int   checks;

  sqm_sequencer_if bus ();

  sqm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_pow(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] r;
    r = 8'd1;
    for (int i = 0; i < int'(b); i++) r = 8'(r * a);
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] b);
    int pop;
    int msb;
    pop = 0;
    msb = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) begin
        pop++;
        msb = i;
      end
    end
`ifdef SQM_EARLY_EXIT_EN
    return msb + 1 + pop;
`else
    return 4 + pop;
`endif
  endfunction

  // Waits for out_valid, counting rising edges; tmo set if it never comes.
  task automatic wait_valid(output int lat, output bit rdy_ok, output bit tmo);
    lat    = 0;
    rdy_ok = 1'b1;
    tmo    = 1'b1;
    while (tmo && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.in_ready) rdy_ok = 1'b0;
      if (bus.out_valid) tmo = 1'b0;
    end
  endtask

  // One request from IDLE at a negedge, out_ready already high; ends at a negedge in IDLE.
  task automatic do_req(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] y, output int lat,
                        output bit rdy_ok, output bit tmo);
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat, rdy_ok, tmo);
    y = bus.Y;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = 8'd0;
    bus.B         = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.Y !== 8'd0)         begin errors++; $display("FAIL reset_y got %0d want 0", bus.Y); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] y;
    int         lat;
    bit         rdy_ok;
    bit         tmo;
    int         want_lat;
`ifdef SQM_EARLY_EXIT_EN
    want_lat = 5;
`else
    want_lat = 6;
`endif
    do_req(8'd3, 4'd5, y, lat, rdy_ok, tmo);
    checks++; if (tmo !== 1'b0)   begin errors++; $display("FAIL basic_timeout no out_valid within bound"); end
    checks++; if (y !== 8'd243)   begin errors++; $display("FAIL basic_y got %0d want 243", y); end
    checks++; if (lat != want_lat) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, want_lat); end
    checks++; if (rdy_ok !== 1'b1) begin errors++; $display("FAIL basic_in_ready got high while busy want low"); end
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle got ov=%b ir=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'd2, 8'd255, 8'd7, 8'd0, 8'd5, 8'd0};
    logic [3:0] vb [6] = '{4'd9, 4'd15, 4'd2, 4'd0, 4'd0, 4'd3};
    logic [7:0] vy [6] = '{8'd0, 8'd255, 8'd49, 8'd1, 8'd1, 8'd0};
`ifdef SQM_EARLY_EXIT_EN
    int         vl [6] = '{6, 8, 3, 1, 1, 4};
`else
    int         vl [6] = '{6, 8, 5, 4, 4, 6};
`endif
    logic [7:0] y;
    int         lat;
    bit         rdy_ok;
    bit         tmo;
    for (int i = 0; i < 6; i++) begin
      do_req(va[i], vb[i], y, lat, rdy_ok, tmo);
      checks++; if (tmo !== 1'b0 || y !== vy[i]) begin
        errors++; $display("FAIL vec_y A=%0d B=%0d got %0d (tmo=%b) want %0d", va[i], vb[i], y, tmo, vy[i]);
      end
      checks++; if (lat != vl[i]) begin
        errors++; $display("FAIL vec_latency A=%0d B=%0d got %0d want %0d", va[i], vb[i], lat, vl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit rdy_ok;
    bit tmo;
    bit stable;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A         = 8'd3;
    bus.B         = 4'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat, rdy_ok, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout no out_valid within bound"); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.Y !== 8'd9 || bus.in_ready !== 1'b0 || busy !== 1'b1) begin
        stable = 1'b0;
        $display("cycle %0d ov=%b y=%0d ir=%b busy=%b", i, bus.out_valid, bus.Y, bus.in_ready, busy);
      end
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold got unstable outputs want ov=1 y=9 ir=0"); end
    // New request presented in the same cycle the result is taken.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 8'd2;
    bus.B         = 4'd3;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0 1 0", bus.out_valid, bus.in_ready, busy);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_next_accept got ir=%b busy=%b want 0 1", bus.in_ready, busy);
    end
    wait_valid(lat, rdy_ok, tmo);
    checks++; if (tmo !== 1'b0 || bus.Y !== 8'd8) begin
      errors++; $display("FAIL bp_next_y got %0d (tmo=%b) want 8", bus.Y, tmo);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] y;
    int         lat;
    bit         rdy_ok;
    bit         tmo;
    bit         saw_valid;
    bus.in_valid = 1'b1;
    bus.A        = 8'd3;
    bus.B        = 4'd15;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Y !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got ir=%b ov=%b y=%0d busy=%b want 1 0 0 0",
                         bus.in_ready, bus.out_valid, bus.Y, busy);
    end
    reset = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got out_valid=1 want 0"); end
    do_req(8'd3, 4'd2, y, lat, rdy_ok, tmo);
    checks++; if (tmo !== 1'b0 || y !== 8'd9) begin
      errors++; $display("FAIL midrst_next_y got %0d (tmo=%b) want 9", y, tmo);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] y;
    int         lat;
    bit         rdy_ok;
    bit         tmo;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_req(8'(a), 4'(b), y, lat, rdy_ok, tmo);
        checks++; if (tmo !== 1'b0 || y !== ref_pow(8'(a), 4'(b))) begin
          errors++; $display("FAIL sweep_y A=%0d B=%0d got %0d want %0d", a, b, y, ref_pow(8'(a), 4'(b)));
        end
        checks++; if (lat != ref_lat(4'(b)) || rdy_ok !== 1'b1) begin
          errors++; $display("FAIL sweep_latency A=%0d B=%0d got %0d want %0d", a, b, lat, ref_lat(4'(b)));
        end
        if (tmo) begin
          $display("FAIL sweep_abort handshake lost, stopping");
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "sweep timeout");
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
